// File: rtl/mmio_bridge.sv
// N-channel MMIO bridge: decodes MEM-stage addresses into peripheral windows,
// runs a ready/timeout handshake per access and stalls the pipeline meanwhile.
module mmio_bridge #(
  parameter int          NCH     = 8,
  parameter int          DW      = 32,
  parameter logic [31:0] BASE    = 32'hFFFF_FC00,
  parameter int          WB      = 4,
  parameter int          TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  input  logic [3:0]        cpu_be,
  input  logic              cpu_rd,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  output logic [NCH-1:0]    p_sel,
  output logic              p_rd,
  output logic              p_wr,
  output logic [WB-1:0]     p_addr,
  output logic [DW-1:0]     p_wdata,
  output logic [3:0]        p_be,
  input  logic [NCH*DW-1:0] p_rdata,
  input  logic [NCH-1:0]    p_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

  stateT          stateReg, stateNext;
  logic [3:0]     chReg;
  logic [WB-1:0]  offsetReg;
  logic [DW-1:0]  wdataReg;
  logic [3:0]     beReg;
  logic           writeReg;
  logic           errReg;
  logic [15:0]    cntReg;
  logic [DW-1:0]  rdataReg;

  logic           hit, isWrite, decodeErr, selReady, timeoutHit;
  logic [3:0]     ch;
  logic [NCH-1:0] selVec;
  logic [DW-1:0]  selData;
  logic [DW-1:0]  chMasked [NCH];

  assign isWrite    = |cpu_be;
  assign ch         = cpu_addr[WB+3:WB];
  assign hit        = (cpu_rd || isWrite) && (cpu_addr[31:WB+4] == BASE[31:WB+4]);
  assign decodeErr  = ({1'b0, ch} >= 5'(NCH));
  assign timeoutHit = (cntReg == 16'(TIMEOUT - 1));

  // Only the latched channel's ready and data are ever looked at.
  for (genvar gi = 0; gi < NCH; gi++) begin : gChan
    assign selVec[gi]   = (chReg == 4'(gi));
    assign chMasked[gi] = selVec[gi] ? p_rdata[gi*DW +: DW] : '0;
  end

  assign selReady = |(p_ready & selVec);

  always_comb begin
    selData = '0;
    for (int k = 0; k < NCH; k++) selData = selData | chMasked[k];
  end

  always_ff @(posedge clk) begin
    if (rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (hit) stateNext = decodeErr ? DONE : ACCESS;
      ACCESS:  if (selReady || timeoutHit) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    p_sel     = '0;
    p_rd      = 1'b0;
    p_wr      = 1'b0;
    cpu_stall = 1'b0;
    cpu_err   = 1'b0;
    case (stateReg)
      IDLE:   cpu_stall = hit;
      ACCESS: begin
        p_sel     = selVec;
        p_rd      = !writeReg;
        p_wr      = writeReg;
        cpu_stall = 1'b1;
      end
      DONE:   cpu_err = errReg;
      default: ;
    endcase
  end

  // Request latches, wait counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      chReg     <= '0;
      offsetReg <= '0;
      wdataReg  <= '0;
      beReg     <= '0;
      writeReg  <= 1'b0;
      errReg    <= 1'b0;
      cntReg    <= '0;
      rdataReg  <= '0;
    end else begin
      case (stateReg)
        IDLE: if (hit) begin
          if (decodeErr) begin
            rdataReg <= '0;
            errReg   <= 1'b1;
          end else begin
            chReg     <= ch;
            offsetReg <= cpu_addr[WB-1:0];
            wdataReg  <= cpu_wdata;
            beReg     <= cpu_be;
            writeReg  <= isWrite;
            errReg    <= cpu_rd && isWrite;
            cntReg    <= '0;
          end
        end
        ACCESS: begin
          cntReg <= cntReg + 16'd1;
          if (selReady) begin
            rdataReg <= writeReg ? '0 : selData;
          end else if (timeoutHit) begin
            rdataReg <= '0;
            errReg   <= 1'b1;
          end
        end
        DONE:    errReg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign p_addr    = offsetReg;
  assign p_wdata   = wdataReg;
  assign p_be      = beReg;
  assign cpu_rdata = rdataReg;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed vector bench for mmio_bridge with a wait-state peripheral model.
module tb_mmio_bridge;
  localparam int NCH   = 8;
  localparam int DW    = 32;
  localparam int WB    = 4;
  localparam int NEVER = 1000;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       cpu_addr;
  logic [DW-1:0]     cpu_wdata;
  logic [3:0]        cpu_be;
  logic              cpu_rd;
  logic [DW-1:0]     cpu_rdata;
  logic              cpu_stall;
  logic              cpu_err;
  logic [NCH-1:0]    p_sel;
  logic              p_rd;
  logic              p_wr;
  logic [WB-1:0]     p_addr;
  logic [DW-1:0]     p_wdata;
  logic [3:0]        p_be;
  logic [NCH*DW-1:0] p_rdata;
  logic [NCH-1:0]    p_ready;

  int                waitN;
  int                accCyc;
  logic              strayEn;
  logic [NCH-1:0]    strayReady;
  int                passed = 0;
  int                total  = 0;

  mmio_bridge #(.NCH(NCH), .DW(DW), .BASE(32'hFFFF_FC00), .WB(WB), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .p_sel(p_sel), .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_be(p_be), .p_rdata(p_rdata), .p_ready(p_ready)
  );

  always #5 clk = ~clk;

  // Peripheral model: the selected channel answers after waitN ACCESS cycles.
  always @(posedge clk) begin
    if (rst || !(|p_sel)) accCyc <= 0;
    else                  accCyc <= accCyc + 1;
    strayReady <= strayEn ? NCH'({1'b0, ~strayReady[0]}) : '0;
  end

  always_comb begin
    p_ready = strayReady;
    if ((|p_sel) && (accCyc >= waitN)) p_ready = p_ready | p_sel;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    int          waitN;
    logic [31:0] pdata;
    int          stall;
    logic [7:0]  sel;
    logic        expRd;
    logic        expWr;
    int          strobes;
    logic [3:0]  paddr;
    logic [31:0] rdata;
    logic        err;
  } vecT;

  function automatic vecT mk(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic rd, input int wn,
                             input logic [31:0] pdata, input int stall, input logic [7:0] sel,
                             input logic erd, input logic ewr, input int strobes,
                             input logic [3:0] paddr, input logic [31:0] rdata, input logic err);
    vecT v;
    v.addr = addr; v.wdata = wdata; v.be = be; v.rd = rd; v.waitN = wn; v.pdata = pdata;
    v.stall = stall; v.sel = sel; v.expRd = erd; v.expWr = ewr; v.strobes = strobes;
    v.paddr = paddr; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  // Presents one request and follows it until the first non-stall cycle.
  task automatic runTxn(input vecT v, input string tag);
    int stallCnt = 0, strobeCnt = 0;
    logic [NCH-1:0] selSeen = '0;
    logic rdSeen = 1'b0, wrSeen = 1'b0, done = 1'b0;
    logic [3:0] paddrSeen = '0, pbeSeen = '0;
    logic [31:0] pwdSeen = '0;
    logic [3:0] chn;
    @(negedge clk);
    cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_be = v.be; cpu_rd = v.rd; waitN = v.waitN;
    for (int k = 0; k < NCH; k++) p_rdata[k*DW +: DW] = 32'hDEAD_0000 | 32'(k);
    chn = v.addr[7:4];
    if (int'(chn) < NCH) p_rdata[int'(chn)*DW +: DW] = v.pdata;
    #1;
    chk({tag, " err_idle"}, 32'(cpu_err), 32'd0);
    for (int c = 0; c < 64; c++) begin
      if (!cpu_stall) begin done = 1'b1; break; end
      stallCnt++;
      if (p_rd || p_wr) strobeCnt++;
      if (|p_sel) begin
        selSeen = selSeen | p_sel; rdSeen = rdSeen | p_rd; wrSeen = wrSeen | p_wr;
        paddrSeen = p_addr; pbeSeen = p_be; pwdSeen = p_wdata;
      end
      @(negedge clk); #1;
    end
    chk({tag, " completed"}, 32'(done), 32'd1);
    chk({tag, " stall_cycles"}, 32'(stallCnt), 32'(v.stall));
    chk({tag, " sel"}, 32'(selSeen), 32'(v.sel));
    chk({tag, " rd_wr"}, {30'd0, rdSeen, wrSeen}, {30'd0, v.expRd, v.expWr});
    chk({tag, " strobe_cycles"}, 32'(strobeCnt), 32'(v.strobes));
    chk({tag, " done_strobes"}, 32'({p_sel, p_rd, p_wr}), 32'd0);
    if (v.strobes > 0) begin
      chk({tag, " p_addr"}, 32'(paddrSeen), 32'(v.paddr));
      chk({tag, " p_be"}, 32'(pbeSeen), 32'(v.be));
      chk({tag, " p_wdata"}, pwdSeen, v.wdata);
    end
    chk({tag, " rdata"}, cpu_rdata, v.rdata);
    chk({tag, " err"}, 32'(cpu_err), 32'(v.err));
    $display("txn %s addr=%h rd=%b be=%b stall=%0d rdata=%h err=%b",
             tag, v.addr, v.rd, v.be, stallCnt, cpu_rdata, cpu_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecT vecs[$];
    vecs.push_back(mk(32'hFFFF_FC74, 32'hA5A5_00FF, 4'b0011, 0, 3, 32'h0, 5, 8'h80, 0, 1, 4, 4'h4, 32'h0, 0));
    vecs.push_back(mk(32'hFFFF_FC20, 32'h0, 4'b0000, 1, 0, 32'h1234_5678, 2, 8'h04, 1, 0, 1, 4'h0, 32'h1234_5678, 0));
    vecs.push_back(mk(32'hFFFF_FC18, 32'h0, 4'b0000, 1, NEVER, 32'h9999_0001, 9, 8'h02, 1, 0, 8, 4'h8, 32'h0, 1));
    vecs.push_back(mk(32'hFFFF_FC6C, 32'h0, 4'b0000, 1, 1, 32'hCAFE_BABE, 3, 8'h40, 1, 0, 2, 4'hC, 32'hCAFE_BABE, 0));
    vecs.push_back(mk(32'hFFFF_FCA0, 32'h0, 4'b0000, 1, 0, 32'h0, 1, 8'h00, 0, 0, 0, 4'h0, 32'h0, 1));
    vecs.push_back(mk(32'h0000_1000, 32'h0, 4'b0000, 1, 0, 32'h0, 0, 8'h00, 0, 0, 0, 4'h0, 32'h0, 0));
    vecs.push_back(mk(32'hFFFF_FB00, 32'h1, 4'b1111, 0, 0, 32'h0, 0, 8'h00, 0, 0, 0, 4'h0, 32'h0, 0));
    vecs.push_back(mk(32'hFFFF_FC00, 32'h0, 4'b0000, 1, 2, 32'h0BAD_F00D, 4, 8'h01, 1, 0, 3, 4'h0, 32'h0BAD_F00D, 0));
    vecs.push_back(mk(32'hFFFF_FC34, 32'h1122_3344, 4'b1111, 1, 0, 32'h0, 2, 8'h08, 0, 1, 1, 4'h4, 32'h0, 1));
    vecs.push_back(mk(32'hFFFF_FC80, 32'h0, 4'b0000, 1, 0, 32'h0, 1, 8'h00, 0, 0, 0, 4'h0, 32'h0, 1));
    vecs.push_back(mk(32'hFFFF_FC40, 32'h0, 4'b0000, 1, 7, 32'h4444_4444, 9, 8'h10, 1, 0, 8, 4'h0, 32'h4444_4444, 0));

    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0; cpu_rd = 1'b0;
    p_rdata = '0; waitN = NEVER; strayEn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset p_sel/rd/wr", 32'({p_sel, p_rd, p_wr}), 32'd0);
    chk("reset p_addr/p_be", 32'({p_addr, p_be}), 32'd0);
    chk("reset p_wdata", p_wdata, 32'd0);
    chk("reset rdata", cpu_rdata, 32'd0);
    chk("reset err/stall", 32'({cpu_err, cpu_stall}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) runTxn(vecs[i], $sformatf("v%0d", i));

    // Reset in the second wait cycle of a ch3 read.
    @(negedge clk);
    cpu_addr = 32'hFFFF_FC3C; cpu_rd = 1'b1; cpu_be = '0; cpu_wdata = 32'h5555_AAAA; waitN = NEVER;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mid sel_before", 32'(p_sel), 32'h08);
    chk("rst_mid wdata_before", p_wdata, 32'h5555_AAAA);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cpu_rd = 1'b0; cpu_wdata = '0;
    #1;
    chk("rst_mid strobes", 32'({p_sel, p_rd, p_wr}), 32'd0);
    chk("rst_mid p_addr/p_be", 32'({p_addr, p_be}), 32'd0);
    chk("rst_mid p_wdata", p_wdata, 32'd0);
    chk("rst_mid rdata", cpu_rdata, 32'd0);
    chk("rst_mid err/stall", 32'({cpu_err, cpu_stall}), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk($sformatf("rst_mid quiet%0d", c), 32'({cpu_err, cpu_stall}), 32'd0);
    end
    runTxn(mk(32'hFFFF_FC3C, 32'h0, 4'b0000, 1, 1, 32'h3333_CCCC, 3, 8'h08, 1, 0, 2, 4'hC, 32'h3333_CCCC, 0), "rst_fresh");

    // ch0 write, then ch5 read back-to-back while ch0 ready toggles.
    runTxn(mk(32'hFFFF_FC08, 32'h0F0F_0F0F, 4'b1100, 0, 0, 32'h0, 2, 8'h01, 0, 1, 1, 4'h8, 32'h0, 0), "b2b_wr0");
    strayEn = 1'b1;
    runTxn(mk(32'hFFFF_FC5C, 32'h0, 4'b0000, 1, 3, 32'h5555_0005, 5, 8'h20, 1, 0, 4, 4'hC, 32'h5555_0005, 0), "b2b_rd5");
    strayEn = 1'b0;

    @(negedge clk);
    cpu_rd = 1'b0; cpu_be = '0;
    #1;
    chk("final idle", 32'({cpu_err, cpu_stall, p_rd, p_wr}), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Parametrised memory-mapped I/O bridge between the MEM pipeline stage and up to NCH peripherals (LEDs, switches, display, PWM, counters, keypad, watchdog). It decodes the MEM-stage address into per-channel windows and runs each access as a handshake with per-channel wait states and a timeout. It stalls the pipeline until the peripheral responds and returns registered read data for write-back. It supersedes the fixed, single-cycle, 16-bit I/O path with an N-channel, full-width, wait-capable one.

## Interface
Parameters:
- NCH, 8 — number of peripheral channels (1..16)
- DW, 32 — data width
- BASE, 32'hFFFF_FC00 — I/O region base; region size is 16 windows of 2^WB bytes
- WB, 4 — window offset bits per channel
- TIMEOUT, 255 — maximum ACCESS cycles before forced completion (1..65535)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  32  MEM-stage address (alu_outM)
- cpu_wdata  in  DW  store data (write_dataM)
- cpu_be  in  4  byte write enables (memwriteM); nonzero means write
- cpu_rd  in  1  load request (mem2regM)
- cpu_rdata  out  DW  read data, valid in DONE
- cpu_stall  out  1  holds the IF/ID/EXE/MEM stages
- cpu_err  out  1  one-cycle pulse in DONE on timeout or decode error
- p_sel  out  NCH  one-hot channel select
- p_rd  out  1  read strobe, level during ACCESS
- p_wr  out  1  write strobe, level during ACCESS
- p_addr  out  WB  offset within the window
- p_wdata  out  DW  latched write data
- p_be  out  4  latched byte enables
- p_rdata  in  NCH*DW  flattened read buses; channel k occupies [k*DW +: DW]
- p_ready  in  NCH  per-channel completion

## Operation
- Hit: (cpu_rd or |cpu_be) and cpu_addr[31:WB+4] == BASE[31:WB+4].
- Channel index: ch = cpu_addr[WB+3:WB].
- Decode error: ch >= NCH.
- Write priority: if cpu_rd and cpu_be are both asserted, the access is a write and cpu_err pulses in DONE.
- A miss, or no request, is ignored: stall stays 0 and the cycle is treated as ordinary memory.

FSM states IDLE, ACCESS, DONE.
- IDLE, on a valid hit:
  - latch ch, addr offset, wdata, be and direction
  - clear the timeout counter
  - go to ACCESS
- IDLE, on a decode-error hit: go directly to DONE with err=1 and rdata=0; no peripheral strobe is issued.
- ACCESS:
  - p_sel[ch] is high; p_rd or p_wr is high; all p_* are held stable
  - the counter increments every cycle
- ACCESS, p_ready[ch]=1: capture p_rdata[ch] into cpu_rdata (reads only; writes capture 0). Go to DONE.
- ACCESS, counter == TIMEOUT-1 without ready: go to DONE with rdata=0 and err=1.
- p_ready from unselected channels is ignored.
- DONE:
  - strobes are low and stall is 0, so the pipeline advances at the end of this cycle
  - the request still present this cycle belongs to the retiring instruction and is ignored
  - next state is IDLE
- cpu_stall = (IDLE and any hit) or ACCESS. This path is combinational, so the hit cycle itself stalls.
- cpu_rdata holds its value until the next capture. cpu_err is high only in DONE.

## Timing
- Reset values:
  - state IDLE; p_sel=0, p_rd=0, p_wr=0
  - p_addr, p_wdata, p_be, cpu_rdata = 0
  - cpu_err=0, counter=0
  - cpu_stall follows its combinational rule
- rst mid-ACCESS: next cycle is IDLE; strobes drop; no DONE is produced and no cpu_err pulses.
- Latency, hit cycle T0:
  - ACCESS at T1
  - ready sampled at T1+n (n ≥ 0 wait cycles), DONE at T2+n
  - stall is high for cycles T0 through T1+n, i.e. n+2 cycles
- Zero-wait peripheral (ready is combinationally high when selected): stall for exactly 2 cycles, DONE at T2.
- Timeout: DONE at T1+TIMEOUT.
- Decode error: DONE at T1, 1 stall cycle.
- Back-to-back hits: the next access may start in the IDLE cycle right after DONE. Throughput is at most 1 access per 3 cycles.
- p_ready is sampled only in ACCESS. A ready seen in the same cycle as a timeout wins: data is captured and err=0.

## Test plan
- Read, zero wait: NCH=8, cpu_rd=1, addr=BASE+0x20 (ch2), p_ready[2] tied 1, p_rdata ch2=0x1234_5678 -> stall high for 2 cycles; p_sel=8'b0000_0100 and p_rd=1 during ACCESS only; cpu_rdata=0x1234_5678 in DONE; err=0.
- Write with 3 wait states: cpu_be=4'b0011, wdata=0xA5A5_00FF, addr=BASE+0x74 (ch7, offset 4); ready asserted on the 4th ACCESS cycle -> p_addr=4, p_be=0011, p_wr held for 4 cycles, stall for 5 cycles, err=0.
- Timeout: TIMEOUT=8, read ch1, ready never asserted -> DONE 8 cycles after ACCESS entry; cpu_rdata=0; cpu_err pulses for exactly 1 cycle.
- Decode error, miss and conflict:
  - NCH=8, addr=BASE+0xA0 (ch10) -> 1 stall cycle, no p_sel, err pulse, rdata=0
  - addr=0x0000_1000 -> no stall, no strobe
  - rd and wr together -> write issued, err=1
- Reset mid-ACCESS: assert rst in the 2nd wait cycle of a ch3 read -> IDLE next cycle; all outputs at reset values; no err pulse; a fresh read afterwards completes normally.
- Back-to-back with stray ready: ch0 write then ch5 read in consecutive instructions, p_ready[0] pulsing during the ch5 access -> ch5 completes only on p_ready[5]; second access starts the cycle after the first DONE.
